// File: rtl/apb_pkg.sv
// Shared types and limits for the APB memory completer and its wait-state counter.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_MAX_WAIT = 15;
    localparam int APB_WAIT_W   = 4;

endpackage

// File: rtl/apb_mem_slave_wait_ctr.sv
// apb_wait_ctr: loadable down-counter that flags when the remaining wait count is zero.
module apb_wait_ctr
    import apb_pkg::*;
#(
    parameter int W = APB_WAIT_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Abort clear wins over a reload; decrement saturates at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= {W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != {W{1'b0}})) begin
            r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_zero = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/apb_mem_slave.sv
// APB completer with a DEPTH-word memory, programmable wait states and PSLVERR decode.
// Optional byte strobes: define APB_SLV_PSTRB_EN to add the PSTRB port.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 16,
    parameter int WAIT_CYC = 0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                PSEL,
    input  logic                PEN,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_SLV_PSTRB_EN
    input  logic [DATA_W/8-1:0] PSTRB,
`endif
    output logic                PREADY,
    output logic                PSLVERR,
    output logic [DATA_W-1:0]   PRDATA
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]         DEPTH_L = DEPTH[ADDR_W:0];
    localparam logic [APB_WAIT_W-1:0]   WAIT_L  = WAIT_CYC[APB_WAIT_W-1:0];

    apb_state_e        r_state;
    apb_state_e        w_state_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_cnt_zero;
    logic              w_in_xfer;
    logic              w_sel_acc;
    logic              w_done;
    logic              w_bad_en;
    logic              w_addr_err;
    logic              w_wr_en;
    logic              w_abort;
    logic              w_load;
    logic              w_dec;
    logic [IDX_W-1:0]  w_idx;

    // r_state records the bus phase seen last cycle, so SETUP means this cycle is the first access cycle.
    assign w_in_xfer  = (r_state == SETUP) || (r_state == ACCESS);
    assign w_sel_acc  = PSEL && PEN;
    assign w_done     = w_in_xfer && w_sel_acc && w_cnt_zero;
    assign w_bad_en   = (r_state == IDLE) && w_sel_acc;
    assign w_addr_err = ({1'b0, PADDR} >= DEPTH_L);
    assign w_wr_en    = w_done && PWRITE && !w_addr_err;
    assign w_abort    = w_in_xfer && !PSEL;
    assign w_load     = PSEL && !PEN;
    assign w_dec      = w_in_xfer && w_sel_acc && !w_cnt_zero;
    assign w_idx      = PADDR[IDX_W-1:0];

    apb_wait_ctr #(
        .W          (APB_WAIT_W)
    ) u_wait_ctr (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_clr      (w_abort),
        .i_load     (w_load),
        .i_load_val (WAIT_L),
        .i_dec      (w_dec),
        .o_zero     (w_cnt_zero)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (PSEL && !PEN) begin
                    w_state_nxt = SETUP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SETUP, ACCESS: begin
                if (!PSEL) begin
                    w_state_nxt = IDLE;
                end else if (!PEN) begin
                    w_state_nxt = SETUP;
                end else if (w_cnt_zero) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = ACCESS;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Response outputs, forced to zero whenever no transfer is completing.
    always_comb begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = {DATA_W{1'b0}};
        if (w_done) begin
            PREADY  = 1'b1;
            PSLVERR = w_addr_err;
            if (!PWRITE && !w_addr_err) begin
                PRDATA = r_mem[w_idx];
            end else begin
                PRDATA = {DATA_W{1'b0}};
            end
        end else if (w_bad_en) begin
            PREADY  = 1'b1;
            PSLVERR = 1'b1;
        end else begin
            PREADY  = 1'b0;
        end
    end

    // Memory array: cleared on reset, written only on a completing in-range write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (w_wr_en) begin
`ifdef APB_SLV_PSTRB_EN
            for (int b = 0; b < DATA_W/8; b++) begin
                if (PSTRB[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= PWDATA[b*8 +: 8];
                end
            end
`else
            r_mem[w_idx] <= PWDATA;
`endif
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench: three completers (WAIT_CYC 0, 3, 2) on a shared bus with one-hot PSEL.
module tb_apb_mem_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  psel = 3'b000;
    logic        pen = 1'b0;
    logic        pwrite = 1'b0;
    logic [7:0]  paddr = 8'd0;
    logic [31:0] pwdata = 32'd0;
`ifdef APB_SLV_PSTRB_EN
    logic [3:0]  pstrb = 4'hF;
`endif
    logic [2:0]  pready;
    logic [2:0]  pslverr;
    logic [31:0] prdata [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_mem_slave #(
            .DATA_W   (32),
            .ADDR_W   (8),
            .DEPTH    (16),
            .WAIT_CYC ((g == 0) ? 0 : ((g == 1) ? 3 : 2))
        ) u_dut (
            .CLK     (clk),
            .RST     (rst),
            .PSEL    (psel[g]),
            .PEN     (pen),
            .PWRITE  (pwrite),
            .PADDR   (paddr),
            .PWDATA  (pwdata),
`ifdef APB_SLV_PSTRB_EN
            .PSTRB   (pstrb),
`endif
            .PREADY  (pready[g]),
            .PSLVERR (pslverr[g]),
            .PRDATA  (prdata[g])
        );
    end

    typedef struct {
        int          k;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the completion edge with PSEL/PEN still high.
    task automatic xfer(input int k, input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] st, output logic [31:0] rd, output logic err, output int ncyc);
        psel   = 3'b001 << k;
        pen    = 1'b0;
        pwrite = wr;
        paddr  = a;
        pwdata = d;
`ifdef APB_SLV_PSTRB_EN
        pstrb  = st;
`endif
        rd   = 32'd0;
        err  = 1'b0;
        ncyc = 0;
        @(posedge clk); #1;
        pen = 1'b1;
        forever begin
            @(negedge clk);
            ncyc++;
            if (pready[k]) begin
                rd  = prdata[k];
                err = pslverr[k];
                break;
            end
            if (ncyc > 40) begin
                checks++;
                failures++;
                $display("FAIL timeout: PREADY got 0 expected 1 within 40 cycles");
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        psel = 3'b000;
        pen  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rd_chk(input int k, input logic [7:0] a, input logic [31:0] exp, input string name);
        logic [31:0] rd;
        logic        er;
        int          nc;
        xfer(k, 1'b0, a, 32'd0, 4'hF, rd, er, nc);
        check(name, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          nc;

        // k, wr, addr, data, strb, exp_rd, exp_err, exp_cyc
        vq.push_back('{0, 1'b1, 8'd3,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1});
        vq.push_back('{0, 1'b0, 8'd3,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 1});
        vq.push_back('{0, 1'b1, 8'd15,  32'hA5A50F0F, 4'hF, 32'h0,        1'b0, 1});
        vq.push_back('{0, 1'b0, 8'd15,  32'h0,        4'hF, 32'hA5A50F0F, 1'b0, 1});
        vq.push_back('{0, 1'b1, 8'd16,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 1});
        vq.push_back('{0, 1'b0, 8'd20,  32'h0,        4'hF, 32'h0,        1'b1, 1});
        vq.push_back('{0, 1'b1, 8'd255, 32'h0BAD0BAD, 4'hF, 32'h0,        1'b1, 1});
        vq.push_back('{0, 1'b0, 8'd0,   32'h0,        4'hF, 32'h0,        1'b0, 1});
        vq.push_back('{0, 1'b0, 8'd15,  32'h0,        4'hF, 32'hA5A50F0F, 1'b0, 1});
        vq.push_back('{0, 1'b0, 8'd3,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 1});
        vq.push_back('{1, 1'b0, 8'd5,   32'h0,        4'hF, 32'h0,        1'b0, 4});
        vq.push_back('{1, 1'b1, 8'd5,   32'h12345678, 4'hF, 32'h0,        1'b0, 4});
        vq.push_back('{1, 1'b0, 8'd5,   32'h0,        4'hF, 32'h12345678, 1'b0, 4});
        vq.push_back('{1, 1'b0, 8'd16,  32'h0,        4'hF, 32'h0,        1'b1, 4});
        vq.push_back('{2, 1'b1, 8'd4,   32'h0F1E2D3C, 4'hF, 32'h0,        1'b0, 3});
        vq.push_back('{2, 1'b0, 8'd4,   32'h0,        4'hF, 32'h0F1E2D3C, 1'b0, 3});
`ifdef APB_SLV_PSTRB_EN
        vq.push_back('{0, 1'b1, 8'd2,   32'hAABBCCDD, 4'hF, 32'h0,        1'b0, 1});
        vq.push_back('{0, 1'b1, 8'd2,   32'h11223344, 4'h5, 32'h0,        1'b0, 1});
        vq.push_back('{0, 1'b0, 8'd2,   32'h0,        4'h0, 32'hAA22CC44, 1'b0, 1});
        vq.push_back('{0, 1'b1, 8'd2,   32'h99999999, 4'h0, 32'h0,        1'b0, 1});
        vq.push_back('{0, 1'b0, 8'd2,   32'h0,        4'hA, 32'hAA22CC44, 1'b0, 1});
`endif

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("reset_pready%0d", k), {31'd0, pready[k]}, 32'd0);
            check($sformatf("reset_pslverr%0d", k), {31'd0, pslverr[k]}, 32'd0);
            check($sformatf("reset_prdata%0d", k), prdata[k], 32'd0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < vq.size(); i++) begin
            xfer(vq[i].k, vq[i].wr, vq[i].addr, vq[i].data, vq[i].strb, rd, er, nc);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vq[i].exp_err});
            check($sformatf("vec%0d_cycles", i), nc, vq[i].exp_cyc);
            if (!vq[i].wr) begin
                check($sformatf("vec%0d_rdata", i), rd, vq[i].exp_rd);
            end
        end
        idle();

        // Abort: PSEL dropped in the second access cycle of a WAIT_CYC=2 write.
        psel = 3'b100; pen = 1'b0; pwrite = 1'b1; paddr = 8'd7; pwdata = 32'hCAFEF00D;
        @(posedge clk); #1 pen = 1'b1;
        @(negedge clk) check("abort_a1_pready", {31'd0, pready[2]}, 32'd0);
        @(posedge clk); #1 psel = 3'b000;
        @(negedge clk) check("abort_a2_pready", {31'd0, pready[2]}, 32'd0);
        @(posedge clk); #1 pen = 1'b0;
        @(posedge clk); #1;
        psel = 3'b100; pen = 1'b1;
        @(negedge clk);
        check("nosetup_pready", {31'd0, pready[2]}, 32'd1);
        check("nosetup_pslverr", {31'd0, pslverr[2]}, 32'd1);
        @(posedge clk); #1;
        idle();
        rd_chk(2, 8'd7, 32'd0, "abort_nowrite");

        // Reset pulsed during an access phase.
        xfer(2, 1'b1, 8'd1, 32'h00000077, 4'hF, rd, er, nc);
        rd_chk(2, 8'd1, 32'h00000077, "pre_reset_rd");
        psel = 3'b100; pen = 1'b0; pwrite = 1'b1; paddr = 8'd8; pwdata = 32'h00000099;
        @(posedge clk); #1 pen = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; psel = 3'b000; pen = 1'b0;
        @(negedge clk);
        check("postrst_pready", {31'd0, pready[2]}, 32'd0);
        check("postrst_pslverr", {31'd0, pslverr[2]}, 32'd0);
        check("postrst_prdata", prdata[2], 32'd0);
        @(posedge clk); #1;
        rd_chk(2, 8'd1, 32'd0, "postrst_w1");
        rd_chk(2, 8'd8, 32'd0, "postrst_w8");
        for (int w = 0; w < 16; w++) begin
            rd_chk(0, w[7:0], 32'd0, $sformatf("postrst_k0_w%0d", w));
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
